besdp_ram_pipelined: RTL and testbench

//  Byte-enabled simple dual-port block RAM: one write port and one independent,

---
 rtl/besdp_ram_pipelined_if.sv | 26 ++
 rtl/besdp_ram_pipelined.sv | 102 ++++++++++
 tb/tb_besdp_ram_pipelined.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/besdp_ram_pipelined_if.sv
// rtl/besdp_ram_pipelined_if.sv - write/read bus bundle for the pipelined byte-enabled SDP RAM
interface besdp_ram_pipelined_if #(
  parameter int ADDRESS_BITWIDTH = 10,
  parameter int DATA_BITWIDTH    = 32,
  parameter int COLUMN_BITWIDTH  = 8
);
  localparam int COLUMN_COUNT = DATA_BITWIDTH / COLUMN_BITWIDTH;

  logic [COLUMN_COUNT-1:0]     wr_en;
  logic [ADDRESS_BITWIDTH-1:0] wr_address;
  logic [DATA_BITWIDTH-1:0]    wr_data;
  logic                        rd_req;
  logic [ADDRESS_BITWIDTH-1:0] rd_address;
  logic                        rd_valid;
  logic [DATA_BITWIDTH-1:0]    rd_data;

  modport master (
    output wr_en, wr_address, wr_data, rd_req, rd_address,
    input  rd_valid, rd_data
  );

  modport slave (
    input  wr_en, wr_address, wr_data, rd_req, rd_address,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/besdp_ram_pipelined.sv
// rtl/besdp_ram_pipelined.sv - byte-enabled simple dual-port RAM with pipelined, valid-tagged read
module besdp_ram_pipelined #(
  parameter     DATA_FILE        = "",
  parameter int ADDRESS_BITWIDTH = 10,
  parameter int DATA_BITWIDTH    = 32,
  parameter int COLUMN_BITWIDTH  = 8,
  parameter int READ_LATENCY     = 1,
  parameter int COLLISION_MODE   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  besdp_ram_pipelined_if.slave  bus
);
  localparam int COLUMN_COUNT = DATA_BITWIDTH / COLUMN_BITWIDTH;
  localparam int DEPTH        = 2 ** ADDRESS_BITWIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("besdp_ram_pipelined: READ_LATENCY must be 1 or 2");
  end
  if (COLUMN_COUNT * COLUMN_BITWIDTH != DATA_BITWIDTH) begin : g_bad_columns
    $error("besdp_ram_pipelined: COLUMN_BITWIDTH must divide DATA_BITWIDTH");
  end

  logic [DATA_BITWIDTH-1:0] mem_q [DEPTH];

  logic [DATA_BITWIDTH-1:0] read_word;
  logic                     src_valid;
  logic [DATA_BITWIDTH-1:0] src_data;
  logic                     rd_valid_q, rd_valid_d;
  logic [DATA_BITWIDTH-1:0] rd_data_q, rd_data_d;

  // Column-granular write; reset blocks writes but never clears the array
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < COLUMN_COUNT; i++) begin
        if (bus.wr_en[i]) begin
          mem_q[bus.wr_address][i*COLUMN_BITWIDTH +: COLUMN_BITWIDTH] <=
            bus.wr_data[i*COLUMN_BITWIDTH +: COLUMN_BITWIDTH];
        end
      end
    end
  end

  // Array word as seen by a request this cycle; write-first mode overlays the enabled new bytes
  always_comb begin
    read_word = mem_q[bus.rd_address];
    if (COLLISION_MODE == 1 && bus.wr_address == bus.rd_address) begin
      for (int i = 0; i < COLUMN_COUNT; i++) begin
        if (bus.wr_en[i]) begin
          read_word[i*COLUMN_BITWIDTH +: COLUMN_BITWIDTH] =
            bus.wr_data[i*COLUMN_BITWIDTH +: COLUMN_BITWIDTH];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                     s1_valid_q;
    logic [DATA_BITWIDTH-1:0] s1_data_q;

    // Stage 1 captures the array word so later writes cannot disturb the request
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s1_valid_q <= 1'b0;
      end else begin
        s1_valid_q <= bus.rd_req;
        if (bus.rd_req) begin
          s1_data_q <= read_word;
        end
      end
    end

    assign src_valid = s1_valid_q;
    assign src_data  = s1_data_q;
  end else begin : g_lat1
    assign src_valid = bus.rd_req;
    assign src_data  = read_word;
  end

  // Output stage: tag valid and hold the last returned word while idle
  always_comb begin
    rd_valid_d = src_valid;
    rd_data_d  = rd_data_q;
    if (src_valid) begin
      rd_data_d = src_data;
    end
  end

  // Output register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_besdp_ram_pipelined.sv
// tb/tb_besdp_ram_pipelined.sv - directed self-checking bench for besdp_ram_pipelined
module tb_besdp_ram_pipelined;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  besdp_ram_pipelined_if #(.ADDRESS_BITWIDTH(10), .DATA_BITWIDTH(32), .COLUMN_BITWIDTH(8)) ifa ();
  besdp_ram_pipelined_if #(.ADDRESS_BITWIDTH(10), .DATA_BITWIDTH(32), .COLUMN_BITWIDTH(8)) ifb ();
  besdp_ram_pipelined_if #(.ADDRESS_BITWIDTH(4),  .DATA_BITWIDTH(16), .COLUMN_BITWIDTH(8)) ifc ();

  // a: latency 1, read-first; b: latency 2, write-first; c: narrow wrap configuration
  besdp_ram_pipelined #(.READ_LATENCY(1), .COLLISION_MODE(0)) u_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  besdp_ram_pipelined #(.READ_LATENCY(2), .COLLISION_MODE(1)) u_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb.slave));
  besdp_ram_pipelined #(.ADDRESS_BITWIDTH(4), .DATA_BITWIDTH(16), .COLUMN_BITWIDTH(8),
                        .READ_LATENCY(1), .COLLISION_MODE(0)) u_c (
    .clk_i(clk), .rst_i(rst), .bus(ifc.slave));

  logic [31:0] stream_data [8] = '{32'h0000_1111, 32'h2222_3333, 32'h4444_5555, 32'h6666_7777,
                                   32'h8888_9999, 32'hAAAA_BBBB, 32'hCCCC_DDDD, 32'hEEEE_FFFF};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] we, input logic [9:0] wa, input logic [31:0] wd,
                     input logic rq, input logic [9:0] ra);
    ifa.wr_en = we; ifa.wr_address = wa; ifa.wr_data = wd; ifa.rd_req = rq; ifa.rd_address = ra;
    ifb.wr_en = we; ifb.wr_address = wa; ifb.wr_data = wd; ifb.rd_req = rq; ifb.rd_address = ra;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv(4'h0, 10'h0, 32'h0, 1'b1, 10'h000);
    ifc.wr_en = 2'b00; ifc.wr_address = 4'h0; ifc.wr_data = 16'h0; ifc.rd_req = 1'b0; ifc.rd_address = 4'h0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ifa.rd_valid !== 1'b0 || ifa.rd_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_a cycle %0d: valid=%b data=%h required valid=0 data=0", c, ifa.rd_valid, ifa.rd_data);
      end
      checks++;
      if (ifb.rd_valid !== 1'b0 || ifb.rd_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_b cycle %0d: valid=%b data=%h required valid=0 data=0", c, ifb.rd_valid, ifb.rd_data);
      end
    end
    rst = 1'b0;
    drv(4'h0, 10'h0, 32'h0, 1'b0, 10'h000);
    tick();
    checks++;
    if (ifa.rd_valid !== 1'b0 || ifa.rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_release: valid=%b data=%h required valid=0 data=0", ifa.rd_valid, ifa.rd_data);
    end
  endtask

  task automatic test_byte_write();
    drv(4'hF, 10'h010, 32'hDEAD_BEEF, 1'b0, 10'h0); tick();
    drv(4'b0010, 10'h010, 32'h0000_AA00, 1'b0, 10'h0); tick();
    drv(4'h0, 10'h0, 32'h0, 1'b1, 10'h010); tick();
    drv(4'h0, 10'h0, 32'h0, 1'b0, 10'h0);
    checks++;
    if (ifa.rd_valid !== 1'b1 || ifa.rd_data !== 32'hDEAD_AAEF) begin
      failures++;
      $display("FAIL byte_write_lat1: valid=%b data=%h required valid=1 data=deadaaef", ifa.rd_valid, ifa.rd_data);
    end
    checks++;
    if (ifb.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL byte_write_lat2_early: valid=%b required 0", ifb.rd_valid);
    end
    tick();
    checks++;
    if (ifb.rd_valid !== 1'b1 || ifb.rd_data !== 32'hDEAD_AAEF) begin
      failures++;
      $display("FAIL byte_write_lat2: valid=%b data=%h required valid=1 data=deadaaef", ifb.rd_valid, ifb.rd_data);
    end
    checks++;
    if (ifa.rd_valid !== 1'b0 || ifa.rd_data !== 32'hDEAD_AAEF) begin
      failures++;
      $display("FAIL byte_write_hold: valid=%b data=%h required valid=0 data=deadaaef", ifa.rd_valid, ifa.rd_data);
    end
  endtask

  task automatic test_collision();
    drv(4'hF, 10'h020, 32'h1122_3344, 1'b0, 10'h0); tick();
    drv(4'b0101, 10'h020, 32'hAABB_CCDD, 1'b1, 10'h020); tick();
    drv(4'h0, 10'h0, 32'h0, 1'b1, 10'h020);
    checks++;
    if (ifa.rd_valid !== 1'b1 || ifa.rd_data !== 32'h1122_3344) begin
      failures++;
      $display("FAIL collision_read_first: valid=%b data=%h required valid=1 data=11223344", ifa.rd_valid, ifa.rd_data);
    end
    tick();
    drv(4'h0, 10'h0, 32'h0, 1'b0, 10'h0);
    checks++;
    if (ifb.rd_valid !== 1'b1 || ifb.rd_data !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL collision_write_first: valid=%b data=%h required valid=1 data=11bb33dd", ifb.rd_valid, ifb.rd_data);
    end
    checks++;
    if (ifa.rd_valid !== 1'b1 || ifa.rd_data !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL collision_followup_a: valid=%b data=%h required valid=1 data=11bb33dd", ifa.rd_valid, ifa.rd_data);
    end
    tick();
    checks++;
    if (ifb.rd_valid !== 1'b1 || ifb.rd_data !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL collision_followup_b: valid=%b data=%h required valid=1 data=11bb33dd", ifb.rd_valid, ifb.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    int pulses_a = 0;
    int pulses_b = 0;
    for (int i = 0; i < 8; i++) begin
      drv(4'hF, 10'(i), stream_data[i], 1'b0, 10'h0);
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      // A write to the address just requested must not disturb the in-flight result
      if (c >= 1 && c <= 8) drv(4'hF, 10'(c - 1), 32'hFFFF_0000, c < 8, 10'(c));
      else drv(4'h0, 10'h0, 32'h0, c < 8, 10'(c));
      tick();
      if (ifa.rd_valid === 1'b1) pulses_a++;
      if (ifb.rd_valid === 1'b1) pulses_b++;
      if (c < 8) begin
        checks++;
        if (ifa.rd_valid !== 1'b1 || ifa.rd_data !== stream_data[c]) begin
          failures++;
          $display("FAIL stream_lat1 idx %0d: valid=%b data=%h required valid=1 data=%h", c, ifa.rd_valid, ifa.rd_data, stream_data[c]);
        end
      end
      if (c >= 1 && c < 9) begin
        checks++;
        if (ifb.rd_valid !== 1'b1 || ifb.rd_data !== stream_data[c-1]) begin
          failures++;
          $display("FAIL stream_lat2 idx %0d: valid=%b data=%h required valid=1 data=%h", c - 1, ifb.rd_valid, ifb.rd_data, stream_data[c-1]);
        end
      end
    end
    checks++;
    if (pulses_a != 8 || pulses_b != 8) begin
      failures++;
      $display("FAIL stream_pulses: lat1=%0d lat2=%0d required 8 and 8", pulses_a, pulses_b);
    end
    // Restore the words overwritten above
    for (int i = 0; i < 8; i++) begin
      drv(4'hF, 10'(i), stream_data[i], 1'b0, 10'h0);
      tick();
    end
    drv(4'h0, 10'h0, 32'h0, 1'b0, 10'h0);
  endtask

  task automatic test_reset_midflight();
    drv(4'h0, 10'h0, 32'h0, 1'b1, 10'h005); tick();
    drv(4'h0, 10'h0, 32'h0, 1'b0, 10'h0);
    rst = 1'b1;
    tick();
    checks++;
    if (ifb.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL midflight_edge1: valid=%b required 0", ifb.rd_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ifb.rd_valid !== 1'b0 || ifb.rd_data !== 32'h0) begin
      failures++;
      $display("FAIL midflight_edge2: valid=%b data=%h required valid=0 data=0", ifb.rd_valid, ifb.rd_data);
    end
    drv(4'h0, 10'h0, 32'h0, 1'b1, 10'h005); tick();
    drv(4'h0, 10'h0, 32'h0, 1'b0, 10'h0); tick();
    checks++;
    if (ifb.rd_valid !== 1'b1 || ifb.rd_data !== 32'hAAAA_BBBB) begin
      failures++;
      $display("FAIL midflight_reread: valid=%b data=%h required valid=1 data=aaaabbbb", ifb.rd_valid, ifb.rd_data);
    end
  endtask

  task automatic test_wrap();
    ifc.wr_en = 2'b11; ifc.wr_address = 4'h0; ifc.wr_data = 16'h1234; tick();
    ifc.wr_en = 2'b11; ifc.wr_address = 4'hF; ifc.wr_data = 16'hBEEF; tick();
    ifc.wr_en = 2'b00; ifc.rd_req = 1'b1; ifc.rd_address = 4'hF; tick();
    checks++;
    if (ifc.rd_valid !== 1'b1 || ifc.rd_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL wrap_top: valid=%b data=%h required valid=1 data=beef", ifc.rd_valid, ifc.rd_data);
    end
    ifc.rd_address = 4'h0; tick();
    ifc.rd_req = 1'b0;
    checks++;
    if (ifc.rd_valid !== 1'b1 || ifc.rd_data !== 16'h1234) begin
      failures++;
      $display("FAIL wrap_zero: valid=%b data=%h required valid=1 data=1234", ifc.rd_valid, ifc.rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_collision();
    test_back_to_back();
    test_reset_midflight();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
